// File: rtl/neo_clk_pkg.sv
// Shared types and constants for the NeoGeo clock-distribution receiver.
package neo_clk_pkg;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } lock_state_e;

  localparam int unsigned PHASE_W     = 2;
  localparam int unsigned MATCH_CNT_W = 8;
  localparam int unsigned ERR_CNT_W   = 4;

  // Generator reset levels; the previous-sample registers start here.
  localparam logic RST_12M = 1'b0;
  localparam logic RST_68K = 1'b0;
  localparam logic RST_6MB = 1'b1;
  localparam logic RST_1HB = 1'b0;

  function automatic logic lvl_12m(input logic [PHASE_W-1:0] p);
    return p[0];
  endfunction

  function automatic logic lvl_6mb(input logic [PHASE_W-1:0] p);
    return ~p[1];
  endfunction

  function automatic logic [PHASE_W-1:0] phase_from_lvl(input logic l12, input logic l6b);
    return {~l6b, l12};
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Tick-gated previous-sample register with registered rise/fall enables.
module edge_pulse #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic d,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    prev_d = prev_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (tick) begin
      prev_d = d;
      rise_d = d & ~prev_q;
      fall_d = ~d & prev_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign prev = prev_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clock_edge_tracker.sv
// Turns sampled divided-clock levels into edge enables and tracks divider phase lock.
module clock_edge_tracker
  import neo_clk_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned ERR_LIMIT  = 2
) (
  input  logic               CLK,
  input  logic               nRESETP,
  input  logic               CLK_EN_24M_N,
  input  logic               CLK_12M,
  input  logic               CLK_68KCLK,
  input  logic               CLK_6MB,
  input  logic               CLK_1HB,
  output logic               EN_12M_RISE,
  output logic               EN_6M_RISE,
  output logic               EN_6M_FALL,
  output logic               EN_68K_RISE,
  output logic               EN_1HB_RISE,
  output logic [PHASE_W-1:0] PHASE,
  output logic               LOCKED,
  output logic               PHASE_ERR
);

  logic tick;
  logic prev_68k;
  logic unused_prev_12m, unused_prev_6mb, unused_prev_1hb;
  logic unused_fall_12m, unused_fall_68k, unused_fall_1hb;

  assign tick = CLK_EN_24M_N;

  edge_pulse #(.RST_VAL(RST_12M)) u_ep_12m (
    .clk(CLK), .rst_n(nRESETP), .tick(tick), .d(CLK_12M),
    .prev(unused_prev_12m), .rise(EN_12M_RISE), .fall(unused_fall_12m)
  );

  edge_pulse #(.RST_VAL(RST_68K)) u_ep_68k (
    .clk(CLK), .rst_n(nRESETP), .tick(tick), .d(CLK_68KCLK),
    .prev(prev_68k), .rise(EN_68K_RISE), .fall(unused_fall_68k)
  );

  // 6MB is inverted: its fall is the 6M rise and vice versa.
  edge_pulse #(.RST_VAL(RST_6MB)) u_ep_6mb (
    .clk(CLK), .rst_n(nRESETP), .tick(tick), .d(CLK_6MB),
    .prev(unused_prev_6mb), .rise(EN_6M_FALL), .fall(EN_6M_RISE)
  );

  edge_pulse #(.RST_VAL(RST_1HB)) u_ep_1hb (
    .clk(CLK), .rst_n(nRESETP), .tick(tick), .d(CLK_1HB),
    .prev(unused_prev_1hb), .rise(EN_1HB_RISE), .fall(unused_fall_1hb)
  );

  lock_state_e             state_q, state_d;
  logic [PHASE_W-1:0]      p_q, p_d, p_pred;
  logic [MATCH_CNT_W-1:0]  match_cnt_q, match_cnt_d, match_inc;
  logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d, err_inc;
  logic                    locked_q, locked_d;
  logic                    phase_err_q, phase_err_d;
  logic                    is_match;

  // A tick matches when levels equal the advanced prediction and 68K toggled.
  always_comb begin
    p_pred    = p_q + PHASE_W'(1);
    is_match  = (CLK_12M == lvl_12m(p_pred)) && (CLK_6MB == lvl_6mb(p_pred)) &&
                (CLK_68KCLK != prev_68k);
    match_inc = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + MATCH_CNT_W'(1);
    err_inc   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    phase_err_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_SEARCH: begin
          p_d         = phase_from_lvl(CLK_12M, CLK_6MB);
          match_cnt_d = '0;
          state_d     = S_VERIFY;
        end
        S_VERIFY: begin
          p_d = p_pred;
          if (is_match) begin
            match_cnt_d = match_inc;
            if (match_inc >= MATCH_CNT_W'(LOCK_COUNT)) begin
              state_d   = S_LOCKED;
              err_cnt_d = '0;
            end
          end else begin
            state_d = S_SEARCH;
          end
        end
        S_LOCKED: begin
          p_d = p_pred;
          if (is_match) begin
            err_cnt_d = '0;
          end else begin
            phase_err_d = 1'b1;
            err_cnt_d   = err_inc;
            if (err_inc >= ERR_CNT_W'(ERR_LIMIT)) begin
              state_d = S_SEARCH;
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      state_q     <= S_SEARCH;
      p_q         <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign PHASE     = p_q;
  assign LOCKED    = locked_q;
  assign PHASE_ERR = phase_err_q;

endmodule

// File: tb/tb_clock_edge_tracker.sv
// Randomized bench for clock_edge_tracker against a per-tick behavioural model.
module tb_clock_edge_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tick, l12, l68, l6b, l1hb;
  logic       en12r, en6r, en6f, en68r, en1hr;
  logic [1:0] phase;
  logic       locked, perr;

  clock_edge_tracker #(.LOCK_COUNT(8), .ERR_LIMIT(2)) dut (
    .CLK(clk), .nRESETP(rst_n), .CLK_EN_24M_N(tick),
    .CLK_12M(l12), .CLK_68KCLK(l68), .CLK_6MB(l6b), .CLK_1HB(l1hb),
    .EN_12M_RISE(en12r), .EN_6M_RISE(en6r), .EN_6M_FALL(en6f),
    .EN_68K_RISE(en68r), .EN_1HB_RISE(en1hr),
    .PHASE(phase), .LOCKED(locked), .PHASE_ERR(perr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference divider: 3-bit DIV (12M=DIV[0], 6MB=~DIV[1], 1HB=~DIV[2]) plus 68K toggle.
  logic [2:0] g_div;
  logic       g_68;

  // Model: previous samples, predicted phase, lock state 0=search 1=verify 2=locked.
  bit m_p12, m_p68, m_p6b, m_p1h;
  int m_state, m_p, m_cnt, m_err;
  bit x_e12, x_e6r, x_e6f, x_e68, x_e1h, x_perr;
  int ticks, lock_tick;

  task automatic gen_reset();
    g_div = 3'd4;
    g_68  = 1'b0;
    l12   = g_div[0];
    l6b   = ~g_div[1];
    l1hb  = ~g_div[2];
    l68   = g_68;
  endtask

  task automatic model_reset();
    m_p12 = 0; m_p68 = 0; m_p6b = 1; m_p1h = 0;
    m_state = 0; m_p = 0; m_cnt = 0; m_err = 0;
    x_e12 = 0; x_e6r = 0; x_e6f = 0; x_e68 = 0; x_e1h = 0; x_perr = 0;
    ticks = 0; lock_tick = 0;
  endtask

  task automatic model_step(input bit t);
    int  pred;
    bit  match;
    x_e12 = 0; x_e6r = 0; x_e6f = 0; x_e68 = 0; x_e1h = 0; x_perr = 0;
    if (t) begin
      ticks++;
      x_e12 = l12 && !m_p12;
      x_e6r = !l6b && m_p6b;
      x_e6f = l6b && !m_p6b;
      x_e68 = l68 && !m_p68;
      x_e1h = l1hb && !m_p1h;
      pred  = (m_p + 1) % 4;
      match = (l12 == bit'(pred % 2)) && (l6b == bit'(pred < 2)) && (l68 != m_p68);
      case (m_state)
        0: begin
          m_p = (l6b ? 0 : 2) + (l12 ? 1 : 0);
          m_cnt = 0;
          m_state = 1;
        end
        1: begin
          m_p = pred;
          if (match) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt >= 8) begin m_state = 2; m_err = 0; end
          end else begin
            m_state = 0;
          end
        end
        default: begin
          m_p = pred;
          if (match) m_err = 0;
          else begin
            x_perr = 1;
            if (m_err < 15) m_err++;
            if (m_err >= 2) m_state = 0;
          end
        end
      endcase
      m_p12 = l12; m_p68 = l68; m_p6b = l6b; m_p1h = l1hb;
    end
  endtask

  // fault: 0 none, 1 invert 6MB, 2 freeze 68K, 3 skip a divider step, 4 random levels
  task automatic do_cycle(input bit t, input int fault);
    if (t) begin
      g_div = g_div + ((fault == 3) ? 3'd2 : 3'd1);
      if (fault != 2) g_68 = ~g_68;
      l12  = g_div[0];
      l6b  = ~g_div[1];
      l1hb = ~g_div[2];
      l68  = g_68;
      if (fault == 1) l6b = ~l6b;
      if (fault == 4) {l12, l68, l6b, l1hb} = 4'($urandom);
    end
    tick = t;
    @(posedge clk);
    #1;
    model_step(t);
    chk("en_12m_rise", 16'(en12r), 16'(x_e12));
    chk("en_6m_rise",  16'(en6r),  16'(x_e6r));
    chk("en_6m_fall",  16'(en6f),  16'(x_e6f));
    chk("en_68k_rise", 16'(en68r), 16'(x_e68));
    chk("en_1hb_rise", 16'(en1hr), 16'(x_e1h));
    chk("phase_err",   16'(perr),  16'(x_perr));
    chk("locked",      16'(locked), 16'(m_state == 2));
    if (m_state == 2) chk("phase", 16'(phase), 16'(m_p));
    if (locked && lock_tick == 0) lock_tick = ticks;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"}, 16'({en12r, en6r, en6f, en68r, en1hr}), 16'd0);
    chk({tag, "_phase"}, 16'(phase), 16'd0);
    chk({tag, "_locked"}, 16'(locked), 16'd0);
    chk({tag, "_perr"}, 16'(perr), 16'd0);
  endtask

  // Assert reset between clock edges and check outputs drop without an edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    check_all_zero(tag);
    gen_reset();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    gen_reset();
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean lock, ticking every other CLK.
    repeat (12) begin do_cycle(1, 0); do_cycle(0, 0); end
    chk("lock_tick", 16'(lock_tick), 16'd9);

    // Single glitch, frozen 68K, then a phase slip.
    repeat (6) begin do_cycle(1, 0); do_cycle(0, 0); end
    do_cycle(1, 1); do_cycle(0, 0);
    repeat (4) begin do_cycle(1, 0); do_cycle(0, 0); end
    chk("glitch_keeps_lock", 16'(locked), 16'd1);
    do_cycle(1, 2); do_cycle(0, 0);
    do_cycle(1, 2); do_cycle(0, 0);
    chk("freeze_drops_lock", 16'(locked), 16'd0);
    repeat (12) begin do_cycle(1, 0); do_cycle(0, 0); end
    do_cycle(1, 3); do_cycle(0, 0);
    repeat (14) begin do_cycle(1, 0); do_cycle(0, 0); end
    chk("relock_after_slip", 16'(locked), 16'd1);

    // Random tick gaps, back-to-back ticks and sparse faults.
    repeat (1500) begin
      bit t;
      int f;
      t = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 40) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_cycle(t, f);
    end

    // Reset mid-VERIFY, then a full relock on back-to-back ticks.
    async_reset("rst_a");
    repeat (4) do_cycle(1, 0);
    async_reset("rst_verify");
    repeat (12) do_cycle(1, 0);
    chk("relock_tick", 16'(lock_tick), 16'd9);
    async_reset("rst_locked");
    repeat (3) do_cycle(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
